// File: rtl/ptw_sv32.sv
// Sv32 page-table walker: two-level PTE walk per TLB miss, single outstanding read, refill or fault strobe.
// Define SV32_SUPERPAGE_EN to refill aligned 4 MiB leaves found at level 1 (otherwise they fault).
module ptw_sv32 #(
   parameter  int PA_WD   = 34,
   localparam int PPN_WD  = 22,
   localparam int ASID_WD = 9,
   localparam int DATA_WD = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [19:0]        req_vpn,
   input  logic [ASID_WD-1:0] req_asid,
   input  logic [PPN_WD-1:0]  satp_ppn,
   input  logic               flush,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [PA_WD-1:0]   mem_req_addr,
   input  logic               mem_resp_valid,
   input  logic [DATA_WD-1:0] mem_resp_data,
   output logic               refill_valid,
   output logic [19:0]        refill_vpn,
   output logic [ASID_WD-1:0] refill_asid,
   output logic [PPN_WD-1:0]  refill_ppn,
   output logic [7:0]         refill_flags,
   output logic               refill_super,
   output logic               fault_valid
);

   typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, FAULT} state_e;

   state_e              state_q, state_d;
   logic [19:0]         vpn_q, vpn_d;
   logic [ASID_WD-1:0]  asid_q, asid_d;
   logic [PPN_WD-1:0]   satp_q, satp_d;
   logic [PPN_WD-1:0]   pte_ppn_q, pte_ppn_d;
   logic                drop_q, drop_d;
   logic [PPN_WD-1:0]   rppn_q, rppn_d;
   logic [7:0]          rflags_q, rflags_d;
`ifdef SV32_SUPERPAGE_EN
   logic                rsuper_q, rsuper_d;
`endif

   logic [PPN_WD-1:0]   pte_ppn;
   logic                pte_bad, pte_leaf, pte_a;
   logic                pte_rsw_unused;

   assign pte_ppn        = mem_resp_data[31:10];
   // Invalid, or the reserved write-without-read encoding.
   assign pte_bad        = ~mem_resp_data[0] | (~mem_resp_data[1] & mem_resp_data[2]);
   assign pte_leaf       = mem_resp_data[1] | mem_resp_data[3];
   assign pte_a          = mem_resp_data[6];
   assign pte_rsw_unused = ^mem_resp_data[9:8];

   always_comb begin
      state_d   = state_q;
      vpn_d     = vpn_q;
      asid_d    = asid_q;
      satp_d    = satp_q;
      pte_ppn_d = pte_ppn_q;
      drop_d    = drop_q;
      rppn_d    = rppn_q;
      rflags_d  = rflags_q;
`ifdef SV32_SUPERPAGE_EN
      rsuper_d  = rsuper_q;
`endif
      case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            if (req_valid) begin
               vpn_d   = req_vpn;
               asid_d  = req_asid;
               satp_d  = satp_ppn;
               state_d = L1_REQ;
            end
         end
         L1_REQ, L0_REQ: begin
            // A flush that races the handshake must still swallow the response.
            if (mem_req_ready) begin
               state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
               if (flush) drop_d = 1'b1;
            end else if (flush) begin
               state_d = IDLE;
            end
         end
         L1_WAIT: begin
            if (mem_resp_valid) begin
               if (drop_q || flush) begin
                  state_d = IDLE;
               end else if (pte_bad) begin
                  state_d = FAULT;
               end else if (!pte_leaf) begin
                  pte_ppn_d = pte_ppn;
                  state_d   = L0_REQ;
               end else if (!pte_a) begin
                  state_d = FAULT;
               end else begin
`ifdef SV32_SUPERPAGE_EN
                  if (pte_ppn[9:0] == 10'd0) begin
                     rppn_d   = pte_ppn;
                     rflags_d = mem_resp_data[7:0];
                     rsuper_d = 1'b1;
                     state_d  = DONE;
                  end else begin
                     state_d = FAULT;
                  end
`else
                  state_d = FAULT;
`endif
               end
            end else if (flush) begin
               drop_d = 1'b1;
            end
         end
         L0_WAIT: begin
            if (mem_resp_valid) begin
               if (drop_q || flush) begin
                  state_d = IDLE;
               end else if (pte_bad || !pte_leaf || !pte_a) begin
                  state_d = FAULT;
               end else begin
                  rppn_d   = pte_ppn;
                  rflags_d = mem_resp_data[7:0];
`ifdef SV32_SUPERPAGE_EN
                  rsuper_d = 1'b0;
`endif
                  state_d  = DONE;
               end
            end else if (flush) begin
               drop_d = 1'b1;
            end
         end
         DONE, FAULT: state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         vpn_q     <= '0;
         asid_q    <= '0;
         satp_q    <= '0;
         pte_ppn_q <= '0;
         drop_q    <= 1'b0;
         rppn_q    <= '0;
         rflags_q  <= '0;
`ifdef SV32_SUPERPAGE_EN
         rsuper_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         vpn_q     <= vpn_d;
         asid_q    <= asid_d;
         satp_q    <= satp_d;
         pte_ppn_q <= pte_ppn_d;
         drop_q    <= drop_d;
         rppn_q    <= rppn_d;
         rflags_q  <= rflags_d;
`ifdef SV32_SUPERPAGE_EN
         rsuper_q  <= rsuper_d;
`endif
      end
   end

   always_comb begin
      mem_req_addr = '0;
      case (state_q)
         L1_REQ:  mem_req_addr = PA_WD'({satp_q, vpn_q[19:10], 2'b00});
         L0_REQ:  mem_req_addr = PA_WD'({pte_ppn_q, vpn_q[9:0], 2'b00});
         default: mem_req_addr = '0;
      endcase
   end

   assign req_ready     = (state_q == IDLE);
   assign mem_req_valid = (state_q == L1_REQ) || (state_q == L0_REQ);
   assign refill_valid  = (state_q == DONE);
   assign fault_valid   = (state_q == FAULT);
   assign refill_vpn    = vpn_q;
   assign refill_asid   = asid_q;
   assign refill_ppn    = rppn_q;
   assign refill_flags  = rflags_q;
`ifdef SV32_SUPERPAGE_EN
   assign refill_super  = rsuper_q;
`else
   assign refill_super  = 1'b0;
`endif

endmodule

// File: tb/tb_ptw_sv32.sv
// Directed bench for ptw_sv32: a walk-level model predicts each cycle's outputs; one process compares them.
// Honors SV32_SUPERPAGE_EN the same way as the design.
module tb_ptw_sv32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [19:0] req_vpn = '0;
   logic [8:0]  req_asid = '0;
   logic [21:0] satp_ppn = '0;
   logic        flush = 1'b0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [33:0] mem_req_addr;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        refill_valid;
   logic [19:0] refill_vpn;
   logic [8:0]  refill_asid;
   logic [21:0] refill_ppn;
   logic [7:0]  refill_flags;
   logic        refill_super;
   logic        fault_valid;

   ptw_sv32 #(.PA_WD(34)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
      .req_asid(req_asid), .satp_ppn(satp_ppn), .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .refill_valid(refill_valid), .refill_vpn(refill_vpn), .refill_asid(refill_asid),
      .refill_ppn(refill_ppn), .refill_flags(refill_flags), .refill_super(refill_super),
      .fault_valid(fault_valid)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Expected outputs for the current cycle, set just after each rising edge.
   logic        chk_en = 1'b0;
   logic        e_ready, e_memv, e_refill, e_fault, e_super, e_zero;
   logic [33:0] e_addr;
   logic [21:0] e_ppn;
   logic [7:0]  e_flags;
   logic [19:0] e_vpn;
   logic [8:0]  e_asid;

   localparam logic [1:0] K_REFILL = 2'd1;
   localparam logic [1:0] K_FAULT  = 2'd2;

   typedef struct packed {
      logic [33:0] a1;
      logic        go0;
      logic [33:0] a0;
      logic [1:0]  kind;
      logic [21:0] ppn;
      logic [7:0]  flags;
      logic        sup;
   } walk_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Walk outcome from the Sv32 rules, using plain address arithmetic.
   function automatic walk_t model(input logic [21:0] satp, input logic [19:0] vpn,
                                   input logic [31:0] p1, input logic [31:0] p0);
      walk_t w;
      logic [21:0] ppn1, ppn0;
      w      = '0;
      w.a1   = 34'(satp) * 34'd4096 + 34'(vpn / 20'd1024) * 34'd4;
      ppn1   = p1[31:10];
      ppn0   = p0[31:10];
      if (p1[0] == 1'b0 || (p1[1] == 1'b0 && p1[2] == 1'b1)) begin
         w.kind = K_FAULT;
      end else if (p1[1] == 1'b0 && p1[3] == 1'b0) begin
         w.go0 = 1'b1;
         w.a0  = 34'(ppn1) * 34'd4096 + 34'(vpn % 20'd1024) * 34'd4;
         if (p0[0] == 1'b1 && !(p0[1] == 1'b0 && p0[2] == 1'b1) &&
             (p0[1] == 1'b1 || p0[3] == 1'b1) && p0[6] == 1'b1) begin
            w.kind  = K_REFILL;
            w.ppn   = ppn0;
            w.flags = p0[7:0];
         end else begin
            w.kind = K_FAULT;
         end
      end else if (p1[6] == 1'b0) begin
         w.kind = K_FAULT;
      end else begin
`ifdef SV32_SUPERPAGE_EN
         if (ppn1 % 22'd1024 == 22'd0) begin
            w.kind  = K_REFILL;
            w.ppn   = ppn1;
            w.flags = p1[7:0];
            w.sup   = 1'b1;
         end else begin
            w.kind = K_FAULT;
         end
`else
         w.kind = K_FAULT;
`endif
      end
      return w;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", req_ready, e_ready);
         chk("mem_req_valid", mem_req_valid, e_memv);
         chk("refill_valid", refill_valid, e_refill);
         chk("fault_valid", fault_valid, e_fault);
         if (e_memv) chk("mem_req_addr", mem_req_addr, e_addr);
         if (e_refill) begin
            chk("refill_ppn", refill_ppn, e_ppn);
            chk("refill_flags", refill_flags, e_flags);
            chk("refill_super", refill_super, e_super);
         end
         if (e_refill || e_fault) begin
            chk("refill_vpn", refill_vpn, e_vpn);
            chk("refill_asid", refill_asid, e_asid);
         end
         if (e_zero) begin
            chk("zero_addr", mem_req_addr, 34'd0);
            chk("zero_vpn", refill_vpn, 20'd0);
            chk("zero_asid", refill_asid, 9'd0);
            chk("zero_ppn", refill_ppn, 22'd0);
            chk("zero_flags", refill_flags, 8'd0);
            chk("zero_super", refill_super, 1'b0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_set(input logic rdy, input logic mv, input logic [33:0] ad,
                          input logic rf, input logic ft);
      e_ready = rdy; e_memv = mv; e_addr = ad; e_refill = rf; e_fault = ft; e_zero = 1'b0;
   endtask

   task automatic idle_tail();
      exp_set(1'b1, 1'b0, '0, 1'b0, 1'b0);
      tick();
      tick();
   endtask

   // fmode: 0 none, 1 flush in L1_WAIT, 2 flush in stalled L1_REQ, 3 flush at accept, 4 flush on final strobe
   task automatic run_walk(input logic [21:0] satp, input logic [19:0] vpn, input logic [8:0] asid,
                           input logic [31:0] p1, input logic [31:0] p0, input int stall, input int fmode);
      walk_t w;
      w = model(satp, vpn, p1, p0);
      exp_set(1'b1, 1'b0, '0, 1'b0, 1'b0);
      req_valid = 1'b1; req_vpn = vpn; req_asid = asid; satp_ppn = satp; flush = (fmode == 3);
      tick();
      req_valid = 1'b0; flush = 1'b0; req_vpn = ~vpn; req_asid = ~asid; satp_ppn = ~satp;
      for (int s = 0; s < stall; s++) begin
         exp_set(1'b0, 1'b1, w.a1, 1'b0, 1'b0);
         mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_00CF;
         flush = (fmode == 2 && s == 0);
         tick();
         mem_resp_valid = 1'b0; flush = 1'b0;
         if (fmode == 2) begin
            idle_tail();
            return;
         end
      end
      exp_set(1'b0, 1'b1, w.a1, 1'b0, 1'b0);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      if (fmode == 1) begin
         exp_set(1'b0, 1'b0, '0, 1'b0, 1'b0);
         flush = 1'b1;
         tick();
         flush = 1'b0;
      end
      exp_set(1'b0, 1'b0, '0, 1'b0, 1'b0);
      mem_resp_valid = 1'b1; mem_resp_data = p1;
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      if (fmode == 1) begin
         idle_tail();
         return;
      end
      if (w.go0) begin
         exp_set(1'b0, 1'b1, w.a0, 1'b0, 1'b0);
         mem_req_ready = 1'b1;
         tick();
         mem_req_ready = 1'b0;
         exp_set(1'b0, 1'b0, '0, 1'b0, 1'b0);
         mem_resp_valid = 1'b1; mem_resp_data = p0;
         tick();
         mem_resp_valid = 1'b0; mem_resp_data = '0;
      end
      exp_set(1'b0, 1'b0, '0, w.kind == K_REFILL, w.kind == K_FAULT);
      e_ppn = w.ppn; e_flags = w.flags; e_super = w.sup; e_vpn = vpn; e_asid = asid;
      flush = (fmode == 4);
      tick();
      flush = 1'b0;
      idle_tail();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      walk_t w;
      exp_set(1'b1, 1'b0, '0, 1'b0, 1'b0);
      e_zero = 1'b1;
      chk_en = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      e_zero = 1'b0;
      tick();

      w = model(22'h00100, 20'h12345, 32'h0008_0001, 32'h1234_50CF);
      chk("pin_l1_addr", w.a1, 34'h0_0010_0120);
      chk("pin_l0_addr", w.a0, 34'h0_0020_0D14);
      chk("pin_leaf_ppn", w.ppn, 22'h048D14);
      chk("pin_leaf_flags", w.flags, 8'hCF);
      w = model(22'h00100, 20'h12345, 32'h4000_00CF, 32'h0);
`ifdef SV32_SUPERPAGE_EN
      chk("pin_super_kind", w.kind, K_REFILL);
      chk("pin_super_ppn", w.ppn, 22'h100000);
`else
      chk("pin_super_kind", w.kind, K_FAULT);
`endif

      run_walk(22'h00100, 20'h12345, 9'h1A5, 32'h0008_0001, 32'h1234_50CF, 0, 0);
      run_walk(22'h00100, 20'h12345, 9'h003, 32'h0000_0000, 32'h0,         0, 0);
      run_walk(22'h00100, 20'h12345, 9'h0F0, 32'h0008_0001, 32'h0000_0005, 0, 0);
      run_walk(22'h00200, 20'hABCDE, 9'h111, 32'h4000_00CF, 32'h0,         0, 0);
      run_walk(22'h00200, 20'hABCDE, 9'h112, 32'h4000_04CF, 32'h0,         0, 0);
      run_walk(22'h3FFFF, 20'hFFFFF, 9'h1FF, 32'h0000_000B, 32'h0,         0, 0);
      run_walk(22'h00055, 20'h00401, 9'h055, 32'h0040_0C01, 32'h0000_0001, 0, 0);
      run_walk(22'h00100, 20'h12345, 9'h0AA, 32'h0008_0001, 32'h1234_50CF, 5, 0);
      run_walk(22'h00100, 20'h12345, 9'h0AB, 32'h0008_0001, 32'h1234_50CF, 0, 1);
      run_walk(22'h00100, 20'h12345, 9'h0AC, 32'h0008_0001, 32'h1234_50CF, 3, 2);
      run_walk(22'h00777, 20'h5A5A5, 9'h0AD, 32'h0008_0001, 32'h7654_30C7, 0, 3);
      run_walk(22'h00100, 20'h12345, 9'h0AE, 32'h0000_0000, 32'h0,         0, 4);
      run_walk(22'h00100, 20'h12345, 9'h0AF, 32'h0008_0001, 32'h1234_50CF, 0, 4);

      // Reset while a level-1 read is outstanding; the late response must be ignored.
      exp_set(1'b1, 1'b0, '0, 1'b0, 1'b0);
      req_valid = 1'b1; req_vpn = 20'h12345; req_asid = 9'h0B0; satp_ppn = 22'h00100;
      tick();
      req_valid = 1'b0;
      exp_set(1'b0, 1'b1, 34'h0_0010_0120, 1'b0, 1'b0);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      exp_set(1'b1, 1'b0, '0, 1'b0, 1'b0);
      e_zero = 1'b1;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0008_0001;
      tick();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      tick();
      e_zero = 1'b0;
      tick();

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
